// File: rtl/fir_out_sched_pkg.sv
// Shared FIR output-scheduler types: decimation rate, frame length, scheduler
// states and the credit count shared with the stream master QUOTA.
package fir_pkg;

  localparam int FIR_FRAME_LEN_W = 16;
  localparam int FIR_OUT_CREDITS = 2;

  typedef logic [3:0]                 FIR_DOWN_RATE;
  typedef logic [FIR_FRAME_LEN_W-1:0] FIR_FRAME_LEN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } FIR_SCHED_STATE;

  function automatic int fir_credit_w(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/fir_out_sched_if.sv
// FIFO-side and stream-master-side signals of the FIR output scheduler.
interface fir_out_sched_if #(
  parameter int RATE_W = 4
);
  logic              buf_empty;
  logic              buf_pop;
  logic              sink_ready;
  logic              credit_ret;
  logic              out_valid;
  logic              out_last;
  logic [RATE_W-1:0] rate_out;

  modport master (
    input  buf_empty, sink_ready, credit_ret,
    output buf_pop, out_valid, out_last, rate_out
  );

  modport slave (
    output buf_empty, sink_ready, credit_ret,
    input  buf_pop, out_valid, out_last, rate_out
  );
endinterface

// File: rtl/fir_out_sched_credit.sv
// Saturating up/down credit counter: take on FIFO pop, give on sink return,
// clear refills to CREDITS; ovf flags a return while already full.
module fir_sched_credit
  import fir_pkg::*;
#(
  parameter int CREDITS = FIR_OUT_CREDITS
) (
  input  logic                             M_AXIS_ACLK,
  input  logic                             M_AXIS_ARESETN,
  input  logic                             take,
  input  logic                             give,
  input  logic                             clear,
  output logic [fir_credit_w(CREDITS)-1:0] credits,
  output logic                             has_credit,
  output logic                             full,
  output logic                             ovf
);
  localparam int CW = fir_credit_w(CREDITS);
  localparam logic [CW-1:0] FULL_CNT = CW'(CREDITS);

  assign full       = (credits == FULL_CNT);
  assign has_credit = (credits != '0);
  assign ovf        = give && !take && full;

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      credits <= FULL_CNT;
    end else if (clear) begin
      credits <= FULL_CNT;
    end else if (take && !give && has_credit) begin
      credits <= credits - CW'(1);
    end else if (give && !take && !full) begin
      credits <= credits + CW'(1);
    end
  end

endmodule

// File: rtl/fir_out_sched.sv
// Frame scheduler between FIR output FIFO and stream master; optional stall
// statistics counter enabled by FIR_OUT_SCHED_STATS_EN.
//
// state | meaning
// IDLE  | waiting for an accepted cfg_start
// RUN   | popping samples while FIFO, sink and credits allow
// DRAIN | final sample popped, waiting for all credits to return
module fir_out_sched
  import fir_pkg::*;
#(
  parameter int CREDITS     = FIR_OUT_CREDITS,
  parameter int FRAME_LEN_W = FIR_FRAME_LEN_W,
  parameter int RATE_W      = $bits(FIR_DOWN_RATE)
) (
  input  logic                   M_AXIS_ACLK,
  input  logic                   M_AXIS_ARESETN,
  input  logic                   cfg_start,
  input  logic                   cfg_abort,
  input  logic [RATE_W-1:0]      cfg_rate,
  input  logic [FRAME_LEN_W-1:0] cfg_frame_len,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
`ifdef FIR_OUT_SCHED_STATS_EN
  output logic [31:0]            stat_stall,
`endif
  fir_out_sched_if.master        sif
);
  localparam int CW = fir_credit_w(CREDITS);

  FIR_SCHED_STATE         state_q, state_d;
  logic [FRAME_LEN_W-1:0] frame_len_q, cnt_q, last_idx;
  logic [RATE_W-1:0]      rate_q;
  logic                   out_valid_q, out_last_q, done_q, err_q;
  logic                   start_acc, pop, final_pop, done_d;
  logic [CW-1:0]          credits;
  logic                   has_credit, full, ovf, refill;

  fir_sched_credit #(
    .CREDITS (CREDITS)
  ) u_credit (
    .M_AXIS_ACLK    (M_AXIS_ACLK),
    .M_AXIS_ARESETN (M_AXIS_ARESETN),
    .take           (pop),
    .give           (sif.credit_ret),
    .clear          (cfg_abort),
    .credits        (credits),
    .has_credit     (has_credit),
    .full           (full),
    .ovf            (ovf)
  );

  assign last_idx = frame_len_q - FRAME_LEN_W'(1);
  // Done is raised as the last credit lands so busy and done change together.
  assign refill   = full || (sif.credit_ret && (credits == CW'(CREDITS - 1)));

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    pop       = 1'b0;
    final_pop = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start && (cfg_frame_len != '0)) begin
          start_acc = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        pop = !sif.buf_empty && sif.sink_ready && has_credit;
        if (pop && (cnt_q == last_idx)) begin
          final_pop = 1'b1;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (refill) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a same-cycle start or pop.
    if (cfg_abort) begin
      state_d   = IDLE;
      start_acc = 1'b0;
      pop       = 1'b0;
      final_pop = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      frame_len_q <= '0;
      cnt_q       <= '0;
      rate_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= pop;
      out_last_q  <= final_pop;
      done_q      <= done_d;
      if (start_acc) begin
        frame_len_q <= cfg_frame_len;
        rate_q      <= cfg_rate;
      end
      if (start_acc || cfg_abort) begin
        cnt_q <= '0;
      end else if (pop) begin
        cnt_q <= cnt_q + FRAME_LEN_W'(1);
      end
      if (ovf) begin
        err_q <= 1'b1;
      end else if (start_acc) begin
        err_q <= 1'b0;
      end
    end
  end

`ifdef FIR_OUT_SCHED_STATS_EN
  logic stall;

  assign stall = (state_q == RUN) && !sif.buf_empty && (!sif.sink_ready || !has_credit);

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      stat_stall <= '0;
    end else if (start_acc) begin
      stat_stall <= '0;
    end else if (stall && (stat_stall != '1)) begin
      stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

  assign sif.buf_pop   = pop;
  assign sif.out_valid = out_valid_q;
  assign sif.out_last  = out_last_q;
  assign sif.rate_out  = rate_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: doc/fir_out_sched.md
Name: fir_out_sched

Overview:
- Frame-level scheduler between the FIR output buffer (FIFO) and the rate-changing stream master.
- Pops samples from the FIFO under credit-based flow control and tags the final sample of each frame with last.
- Latches the decimation rate and holds it stable on rate_out for the whole frame.
- Reports done when every credit issued for the frame has been returned.

Parameters:
- CREDITS, 2, max samples outstanding between FIFO pop and sink credit return; matches the stream master QUOTA.
- FRAME_LEN_W, 16, width of the frame-length config and sample counter.
- RATE_W, 4, width of the decimation rate; equals $bits(FIR_DOWN_RATE).

Ports:
- M_AXIS_ACLK  input  1  clock
- M_AXIS_ARESETN  input  1  asynchronous reset, active-low
- cfg_start  input  1  pulse; starts a frame when IDLE
- cfg_abort  input  1  pulse; returns to IDLE from any state
- cfg_rate  input  RATE_W  decimation rate, sampled on accepted start
- cfg_frame_len  input  FRAME_LEN_W  samples per frame, sampled on accepted start
- buf_empty  input  1  output FIFO empty
- buf_pop  output  1  FIFO read strobe; data is valid the next cycle
- sink_ready  input  1  stream master is_ready
- credit_ret  input  1  pulse; sink returns one credit
- out_valid  output  1  sample valid toward the stream master (buffer_out.valid)
- out_last  output  1  last_in toward the stream master; qualified by out_valid
- rate_out  output  RATE_W  latched rate toward the stream master
- busy  output  1  high in RUN or DRAIN
- done  output  1  one-cycle pulse at frame completion
- err  output  1  sticky credit-overflow flag; cleared by reset or accepted start

Behaviour:
- Reset values: all outputs 0; state IDLE; credit counter = CREDITS; sample counter 0.
- IDLE:
  - cfg_start with cfg_frame_len != 0: latch rate and frame_len, clear err and the sample counter, go to RUN.
  - cfg_start with cfg_frame_len == 0: ignored; stay in IDLE, no done.
- RUN:
  - buf_pop = !buf_empty && sink_ready && credits != 0 (combinational).
  - Each pop decrements credits and increments the sample counter.
  - The pop at counter == frame_len-1 is the final pop; go to DRAIN the next cycle. No pops occur in DRAIN.
- Output pipeline: out_valid is buf_pop registered (latency 1). out_last is registered and is high only on the final sample's out_valid cycle.
- DRAIN: when credits == CREDITS, pulse done for one cycle and go to IDLE. busy falls in the same cycle.
- Credit counter:
  - pop and credit_ret in the same cycle: net change 0.
  - credit_ret with credits == CREDITS and no simultaneous pop: counter saturates and err is set.
  - Credits are never negative, because pop requires credits != 0.
- cfg_start outside IDLE: ignored; latched config is unchanged.
- rate_out changes only on an accepted start and is stable for the whole frame.
- cfg_abort in any state:
  - Next cycle: state IDLE, credits = CREDITS, sample counter 0.
  - out_valid and out_last forced to 0 in that cycle, including a pending registered sample.
  - No done pulse.
  - Abort has priority over a simultaneous start.
- Asynchronous reset mid-frame gives reset values immediately; no partial last is emitted.
- Sample counter width FRAME_LEN_W; frame_len = 2^FRAME_LEN_W-1 is supported with no wrap.

Optional Feature:
- Macro: FIR_OUT_SCHED_STATS_EN.
- Defined: adds output stat_stall 32 bits, a saturating count of RUN cycles with !buf_empty && (!sink_ready || credits == 0). Cleared on reset and on accepted start, held in IDLE, unaffected by abort.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package (fir_pkg):
  - existing FIR_DOWN_RATE typedef;
  - FIR_SCHED_STATE enum {IDLE, RUN, DRAIN};
  - FIR_FRAME_LEN typedef logic[FRAME_LEN_W-1:0];
  - constant FIR_OUT_CREDITS = 2.
- Sub-module fir_sched_credit: up/down credit counter with saturation and an overflow flag. Parameter CREDITS; inputs take, give, clear; outputs credits, has_credit, full, ovf.

Test Plan:
- Basic frame: rate=3, frame_len=8, FIFO always non-empty, sink_ready=1, credit_ret 2 cycles after each out_valid. Expect 8 pops, 8 out_valid, out_last only on the 8th, rate_out=3 throughout, done one cycle after the last credit returns.
- Credit stall: CREDITS=2, credit_ret withheld. Expect exactly 2 pops, then buf_pop=0 until credit_ret. Each return allows exactly one further pop. If FIR_OUT_SCHED_STATS_EN, stat_stall equals the stalled cycle count.
- Empty and not-ready gaps: randomly toggle buf_empty and sink_ready, frame_len=5. Expect no pop while either blocks, 5 samples total, single last, single done.
- Abort mid-frame: frame_len=10, abort after 4 pops with a sample in flight. Expect out_valid=0 in the next cycle, busy=0, no done. A following start with frame_len=2 runs cleanly with credits fully restored.
- Boundaries:
  - frame_len=1: one pop with out_last set.
  - frame_len=0: start ignored.
  - cfg_start during RUN with rate=7: ignored, rate_out unchanged.
- Credit overflow: spurious credit_ret in IDLE. Expect err=1 and credits stay at 2; err clears on the next accepted start.
